sad_search_ctrl: RTL
====================

# sad_search_ctrl

Sequencer for one full-search motion-estimation pass around the 4x4 SAD processing element. On `start` it steps through every candidate displacement (dx, dy) of a ±RANGE search window in raster order, one per cycle. For each candidate it drives the PE `enable` and the displacement that the window-fetch logic uses to present the reference block. It pairs each returned SAD with its displacement, keeps the running minimum, and reports the best motion vector with a one-cycle `done` pulse.

## Interface
- RANGE, 4: search half-width; candidates dx, dy in −RANGE..+RANGE; N = (2·RANGE+1)² candidates (81 at default)
- DW, 4: signed displacement width; RANGE ≤ 2^(DW−1)−1 is required
- SAD_W, 12: SAD width, matching the PE output
- clk  in  1  clock, all state updated on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive
- pe_enable  out  1  drive to PE enable; high exactly while a candidate is issued
- cand_dx  out  DW  signed dx of the candidate being issued
- cand_dy  out  DW  signed dy of the candidate being issued
- sad_in  in  SAD_W  PE sum output
- best_sad  out  SAD_W  minimum SAD of the last completed pass
- best_dx  out  DW  dx of best_sad
- best_dy  out  DW  dy of best_sad
- done  out  1  single-cycle pulse; best_* are valid from this cycle on

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on start. At that edge: cand_dx = cand_dy = −RANGE, best_sad = all-ones (2^SAD_W−1), best_dx = best_dy = 0.
- ISSUE: pe_enable = 1. The dx counter increments each cycle. At +RANGE, dx wraps to −RANGE and dy increments.
- ISSUE → DRAIN on the cycle that issues (+RANGE, +RANGE).
- DRAIN: pe_enable = 0; captures the last SAD. Then DRAIN → DONE.
- DONE: done = 1 for one cycle, then → IDLE.
- The PE registers its sum 1 cycle after enable, so the displacement is delayed by one cycle alongside a valid flag (a registered copy of pe_enable).
- When the valid flag is high and sad_in < best_sad (strict, unsigned), best_sad, best_dx and best_dy load from sad_in and the delayed displacement.
- Ties keep the earlier raster candidate.
- PE max SAD is 16·255 = 4080 < 4095, so the first candidate always loads.
- start while not IDLE is ignored.
- cand_dx/cand_dy hold their last value outside ISSUE. best_* hold until the next accepted start.
- rst_n low in any state → IDLE next edge; the pass is abandoned with no done pulse.

## Timing
- Reset values: busy = 0, pe_enable = 0, done = 0, cand_dx = cand_dy = 0, best_sad = all-ones, best_dx = best_dy = 0, delay valid = 0.
- start high at edge E0 (IDLE): ISSUE during cycles 1..N, candidate k (0-based) issued in cycle k+1.
- The SAD for candidate k arrives on sad_in in cycle k+2 and is compared there.
- DRAIN is cycle N+1 and compares the last candidate. DONE is cycle N+2.
- Start-to-done latency is N+2 cycles (83 at default). A new start is accepted in the cycle after done, giving back-to-back passes every N+3 cycles.
- All outputs are registered; no combinational path from sad_in or start to any output.

## Structure
- Package sad_pkg holds:
  - SAD_W = 12 and SAD_MAX = all-ones
  - the state enum {IDLE, ISSUE, DRAIN, DONE}
  - the PE latency constant PE_LAT = 1, which sets the displacement delay depth
- Sub-module sad_min_tracker holds the compare-and-hold of best_sad/best_dx/best_dy. Ports: clk, rst_n, init, valid, sad, dx, dy, best_*.
- The FSM and raster counters stay in sad_search_ctrl.

## Test plan
- **Default flow:** RANGE = 4. A PE model returns 100 for every candidate except 37 at (dx = 2, dy = −1). Required: done at cycle 83 after start, best_sad = 37, best = (2, −1), pe_enable high for exactly 81 cycles.
- **Tie-break:** SAD = 0 at both (−1, −3) and (3, 2). Required: best = (−1, −3).
- **Corners:** minimum at (−4, −4) and, in a separate run, at (+4, +4). Required: the first and last candidates are captured correctly, including the DRAIN capture.
- **Start while busy:** pulse start at cycles 10 and 40 of a pass. Required: no restart, done at cycle 83, then an immediate new start is accepted with best_sad re-initialised to 4095.
- **Reset mid-pass:** rst_n low at cycle 30. Required: next cycle busy = 0, pe_enable = 0, best_sad = 4095, no done pulse.
- **Small window:** RANGE = 1. Required: candidates issued in order (−1,−1), (0,−1), (1,−1), …, (1,1), and done at cycle 11.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared types and constants for the full-search SAD motion-estimation sequencer.
package sad_pkg;

  localparam int unsigned SAD_W  = 12;
  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  // The PE registers its sum once, so the displacement is delayed by this many cycles.
  localparam int unsigned PE_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sad_min_tracker.sv
// Running-minimum tracker: keeps the smallest SAD and its displacement.
module sad_min_tracker #(
  parameter int unsigned SAD_W = 12,
  parameter int unsigned DW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  input  logic                    valid,
  input  logic        [SAD_W-1:0] sad,
  input  logic signed [DW-1:0]    dx,
  input  logic signed [DW-1:0]    dy,
  output logic        [SAD_W-1:0] best_sad,
  output logic signed [DW-1:0]    best_dx,
  output logic signed [DW-1:0]    best_dy
);

  logic        [SAD_W-1:0] best_sad_q;
  logic signed [DW-1:0]    best_dx_q;
  logic signed [DW-1:0]    best_dy_q;

  // Strict less-than: ties keep the earlier raster candidate.
  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      best_sad_q <= '1;
      best_dx_q  <= '0;
      best_dy_q  <= '0;
    end else if (valid && (sad < best_sad_q)) begin
      best_sad_q <= sad;
      best_dx_q  <= dx;
      best_dy_q  <= dy;
    end
  end

  assign best_sad = best_sad_q;
  assign best_dx  = best_dx_q;
  assign best_dy  = best_dy_q;

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search sequencer: raster-scans a +/-RANGE window, issues candidates to the
// SAD PE and reports the best motion vector with a single-cycle done pulse.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int unsigned RANGE = 4,
  parameter int unsigned DW    = 4,
  parameter int unsigned SAD_W = sad_pkg::SAD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    pe_enable,
  output logic signed [DW-1:0]    cand_dx,
  output logic signed [DW-1:0]    cand_dy,
  input  logic        [SAD_W-1:0] sad_in,
  output logic        [SAD_W-1:0] best_sad,
  output logic signed [DW-1:0]    best_dx,
  output logic signed [DW-1:0]    best_dy,
  output logic                    done
);

  localparam logic signed [DW-1:0] RMAX = DW'(RANGE);
  localparam logic signed [DW-1:0] RMIN = -RMAX;
  localparam logic signed [DW-1:0] ONE  = DW'(1);

  state_t state_q, state_d;

  logic signed [DW-1:0] cand_dx_q, cand_dx_d;
  logic signed [DW-1:0] cand_dy_q, cand_dy_d;
  logic                 busy_q, busy_d;
  logic                 pe_en_q, pe_en_d;
  logic                 done_q, done_d;

  logic                 vld_q    [PE_LAT];
  logic signed [DW-1:0] dx_dly_q [PE_LAT];
  logic signed [DW-1:0] dy_dly_q [PE_LAT];

  logic accept;
  logic last_cand;

  assign accept    = (state_q == IDLE) && start;
  assign last_cand = (cand_dx_q == RMAX) && (cand_dy_q == RMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cand_dx_q <= '0;
      cand_dy_q <= '0;
      busy_q    <= 1'b0;
      pe_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_dx_q <= cand_dx_d;
      cand_dy_q <= cand_dy_d;
      busy_q    <= busy_d;
      pe_en_q   <= pe_en_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start)     state_d = ISSUE;
      ISSUE: if (last_cand) state_d = DRAIN;
      DRAIN:                state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they describe without any combinational path to the pins.
  always_comb begin
    busy_d  = (state_d != IDLE);
    pe_en_d = (state_d == ISSUE);
    done_d  = (state_d == DONE);
  end

  always_comb begin
    cand_dx_d = cand_dx_q;
    cand_dy_d = cand_dy_q;
    if (accept) begin
      cand_dx_d = RMIN;
      cand_dy_d = RMIN;
    end else if ((state_q == ISSUE) && !last_cand) begin
      if (cand_dx_q == RMAX) begin
        cand_dx_d = RMIN;
        cand_dy_d = cand_dy_q + ONE;
      end else begin
        cand_dx_d = cand_dx_q + ONE;
      end
    end
  end

  // Displacement travels alongside the PE pipeline so it meets its SAD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PE_LAT; i++) begin
        vld_q[i]    <= 1'b0;
        dx_dly_q[i] <= '0;
        dy_dly_q[i] <= '0;
      end
    end else begin
      vld_q[0]    <= pe_en_q;
      dx_dly_q[0] <= cand_dx_q;
      dy_dly_q[0] <= cand_dy_q;
      for (int unsigned i = 1; i < PE_LAT; i++) begin
        vld_q[i]    <= vld_q[i-1];
        dx_dly_q[i] <= dx_dly_q[i-1];
        dy_dly_q[i] <= dy_dly_q[i-1];
      end
    end
  end

  sad_min_tracker #(
    .SAD_W (SAD_W),
    .DW    (DW)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (accept),
    .valid    (vld_q[PE_LAT-1]),
    .sad      (sad_in),
    .dx       (dx_dly_q[PE_LAT-1]),
    .dy       (dy_dly_q[PE_LAT-1]),
    .best_sad (best_sad),
    .best_dx  (best_dx),
    .best_dy  (best_dy)
  );

  assign busy      = busy_q;
  assign pe_enable = pe_en_q;
  assign done      = done_q;
  assign cand_dx   = cand_dx_q;
  assign cand_dy   = cand_dy_q;

endmodule
